// File: rtl/seq_arith_pkg.sv
// -----------------------------------------------------------------------------
// seq_arith_pkg
// Shared definitions for the digit-serial arithmetic blocks.
//   MODE_ADD / MODE_SUB   : operation mode encoding (latched on digit 0).
//   SEQ_ARITH_PARAMS_OK   : parameter-legality macro (word/digit widths).
//   seq_arith_params_ok() : constant-function form of the same check, usable
//                           in generate conditions.
// -----------------------------------------------------------------------------
`ifndef SEQ_ARITH_PKG_MACROS
`define SEQ_ARITH_PKG_MACROS
// Legal when the digit is at least one bit wide, the word is at least two
// bits wide and the word splits into a whole number of digits.
`define SEQ_ARITH_PARAMS_OK(nb, db) (((db) >= 1) && ((nb) >= 2) && (((nb) % (db)) == 0))
`endif

package seq_arith_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic bit seq_arith_params_ok(input int nbits, input int dbits);
        return `SEQ_ARITH_PARAMS_OK(nbits, dbits);
    endfunction

endpackage

// File: rtl/seq_arith_digit_add.sv
// -----------------------------------------------------------------------------
// seq_arith_digit_add
// Purely combinational p_dbits-wide digit adder: {cout, sum} = a + b + cin.
//   a, b  : digit operands (b already inverted by the caller for subtract)
//   cin   : carry in
//   sum   : p_dbits-wide sum digit
//   cout  : carry out of the digit MSB
//   cmsb  : carry into the digit MSB; XOR with cout gives signed overflow
//           when this digit holds the word's sign bit
// -----------------------------------------------------------------------------
module seq_arith_digit_add #(
    parameter int p_dbits = 1
) (
    input  logic [p_dbits-1:0] a,
    input  logic [p_dbits-1:0] b,
    input  logic               cin,
    output logic [p_dbits-1:0] sum,
    output logic               cout,
    output logic               cmsb
);

    logic [p_dbits:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b} + {{p_dbits{1'b0}}, cin};
    assign sum      = full_sum[p_dbits-1:0];
    assign cout     = full_sum[p_dbits];

    generate
        if (p_dbits == 1) begin : g_single_bit
            // A one-bit digit has no lower bits: the carry into its MSB is cin.
            assign cmsb = cin;
        end else begin : g_multi_bit
            // Add only the bits below the MSB; the top bit of this narrower
            // sum is exactly the carry entering the MSB position.
            logic [p_dbits-1:0] low_sum;
            assign low_sum = {1'b0, a[p_dbits-2:0]} + {1'b0, b[p_dbits-2:0]}
                           + {{(p_dbits-1){1'b0}}, cin};
            assign cmsb    = low_sum[p_dbits-1];
        end
    endgenerate

endmodule

// File: rtl/seq_arith_serial_addsub.sv
// -----------------------------------------------------------------------------
// seq_arith_serial_addsub
// Digit-serial adder/subtractor. Operands arrive one p_dbits-wide digit per
// cycle, LSB digit first; the result digit stream leaves one cycle later.
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset, abandons any partial word
//   in_val   : in0/in1/sub valid this cycle (no backpressure)
//   in0, in1 : operand A / operand B digits
//   sub      : 0 = A+B, 1 = A-B; only looked at on digit 0 of a word
//   out_val  : out holds a valid result digit
//   out      : result digit
//   done     : out is the last (MSB) digit of the word
//   cout     : word carry-out (for subtract, 1 = no borrow); 0 unless done
//   ovf      : two's-complement overflow of the word; 0 unless done
// -----------------------------------------------------------------------------
module seq_arith_serial_addsub
    import seq_arith_pkg::*;
#(
    parameter int p_nbits = 8,
    parameter int p_dbits = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    input  logic [p_dbits-1:0] in0,
    input  logic [p_dbits-1:0] in1,
    input  logic               sub,
    output logic               out_val,
    output logic [p_dbits-1:0] out,
    output logic               done,
    output logic               cout,
    output logic               ovf
);

    localparam int NDIGITS = p_nbits / p_dbits;
    localparam int CW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

    generate
        if (!seq_arith_params_ok(p_nbits, p_dbits)) begin : g_bad_params
            $error("seq_arith_serial_addsub: illegal p_nbits/p_dbits combination");
        end
    endgenerate

    // State
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               carry_q,   carry_d;
    logic               mode_q,    mode_d;
    logic               out_val_q, out_val_d;
    logic [p_dbits-1:0] out_q,     out_d;
    logic               done_q,    done_d;
    logic               cout_q,    cout_d;
    logic               ovf_q,     ovf_d;

    // Datapath
    logic               first_digit;
    logic               last_digit;
    logic               mode_eff;
    logic               cin_eff;
    logic [p_dbits-1:0] b_eff;
    logic [p_dbits-1:0] dig_sum;
    logic               dig_cout;
    logic               dig_cmsb;

    assign first_digit = (cnt_q == '0);
    assign last_digit  = (cnt_q == LAST_CNT);

    // Digit 0 takes its mode straight from the sub pin so the word needs no
    // setup cycle; later digits use the mode latched on digit 0.
    assign mode_eff = first_digit ? sub : mode_q;
    assign b_eff    = (mode_eff == MODE_SUB) ? ~in1 : in1;
    // Subtract is A + ~B + 1: the +1 enters as carry-in of digit 0.
    assign cin_eff  = first_digit ? sub : carry_q;

    seq_arith_digit_add #(
        .p_dbits (p_dbits)
    ) u_digit_add (
        .a    (in0),
        .b    (b_eff),
        .cin  (cin_eff),
        .sum  (dig_sum),
        .cout (dig_cout),
        .cmsb (dig_cmsb)
    );

    always_comb begin
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        mode_d    = mode_q;
        out_val_d = 1'b0;
        out_d     = '0;
        done_d    = 1'b0;
        cout_d    = 1'b0;
        ovf_d     = 1'b0;

        if (in_val) begin
            mode_d    = mode_eff;
            out_val_d = 1'b1;
            out_d     = dig_sum;
            if (last_digit) begin
                // Clearing carry here keeps back-to-back words independent.
                cnt_d   = '0;
                carry_d = 1'b0;
                done_d  = 1'b1;
                cout_d  = dig_cout;
                ovf_d   = dig_cmsb ^ dig_cout;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                carry_d = dig_cout;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            mode_q    <= MODE_ADD;
            out_val_q <= 1'b0;
            out_q     <= '0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            mode_q    <= mode_d;
            out_val_q <= out_val_d;
            out_q     <= out_d;
            done_q    <= done_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_val = out_val_q;
    assign out     = out_q;
    assign done    = done_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_seq_arith_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_seq_arith_serial_addsub
// Two instances share clock and reset: dut1 (8-bit word, 1-bit digits) and
// dut2 (8-bit word, 2-bit digits). Expected words come from whole-word integer
// arithmetic; digits, carry-out and overflow are derived from that.
// -----------------------------------------------------------------------------
module tb_seq_arith_serial_addsub;

    logic       clk;
    logic       reset;

    logic       v1, s1;
    logic [0:0] a1, b1;
    logic       o_val1, done1, cout1, ovf1;
    logic [0:0] o1;

    logic       v2, s2;
    logic [1:0] a2, b2;
    logic       o_val2, done2, cout2, ovf2;
    logic [1:0] o2;

    int checks = 0;
    int errors = 0;

    seq_arith_serial_addsub #(.p_nbits(8), .p_dbits(1)) dut1 (
        .clk(clk), .reset(reset), .in_val(v1), .in0(a1), .in1(b1), .sub(s1),
        .out_val(o_val1), .out(o1), .done(done1), .cout(cout1), .ovf(ovf1)
    );

    seq_arith_serial_addsub #(.p_nbits(8), .p_dbits(2)) dut2 (
        .clk(clk), .reset(reset), .in_val(v2), .in0(a2), .in1(b2), .sub(s2),
        .out_val(o_val2), .out(o2), .done(done2), .cout(cout2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Whole-word reference: plain integer arithmetic on 8-bit operands.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input bit s,
                         output logic [7:0] res, output bit c, output bit o);
        int sa, sb, r;
        sa = (a > 127) ? int'(a) - 256 : int'(a);
        sb = (b > 127) ? int'(b) - 256 : int'(b);
        if (s) begin
            res = 8'((int'(a) - int'(b)) & 255);
            c   = (a >= b);          // no borrow
            r   = sa - sb;
        end else begin
            res = 8'((int'(a) + int'(b)) & 255);
            c   = ((int'(a) + int'(b)) > 255);
            r   = sa + sb;
        end
        o = (r < -128) || (r > 127);
    endtask

    // One clock: drive one DUT (the other idles), then check its outputs.
    task automatic step(input int which, input string tag, input bit v,
                        input logic [1:0] a, input logic [1:0] b, input bit s,
                        input logic [1:0] e_out, input bit e_done, input bit e_cout,
                        input bit e_ovf, output logic [1:0] got);
        if (which == 1) begin
            v1 = v; a1 = a[0]; b1 = b[0]; s1 = s; v2 = 1'b0;
        end else begin
            v2 = v; a2 = a; b2 = b; s2 = s; v1 = 1'b0;
        end
        @(posedge clk);
        #1;
        if (which == 1) begin
            chk({tag, " out_val"}, 32'(o_val1), 32'(v));
            chk({tag, " out"},     32'(o1),     32'(e_out));
            chk({tag, " done"},    32'(done1),  32'(e_done));
            chk({tag, " cout"},    32'(cout1),  32'(e_cout));
            chk({tag, " ovf"},     32'(ovf1),   32'(e_ovf));
            got = {1'b0, o1};
        end else begin
            chk({tag, " out_val"}, 32'(o_val2), 32'(v));
            chk({tag, " out"},     32'(o2),     32'(e_out));
            chk({tag, " done"},    32'(done2),  32'(e_done));
            chk({tag, " cout"},    32'(cout2),  32'(e_cout));
            chk({tag, " ovf"},     32'(ovf2),   32'(e_ovf));
            got = o2;
        end
    endtask

    task automatic bubble(input int which, input string tag);
        logic [1:0] junk;
        step(which, {tag, " bubble"}, 1'b0, 2'($urandom), 2'($urandom), 1'($urandom),
             2'b00, 1'b0, 1'b0, 1'b0, junk);
    endtask

    // Sends n_send digits of A op B (a full word when n_send equals the digit
    // count). sub is driven correctly on digit 0 and randomly afterwards.
    task automatic run_word(input int which, input string name, input logic [7:0] a,
                            input logic [7:0] b, input bit s, input int bub_at,
                            input int bub_n, input bit rand_bub, input int n_send);
        int         db, nd;
        logic [7:0] res, got_word;
        bit         ec, eo, last;
        logic [1:0] ad, bd, rd, got;
        db = (which == 1) ? 1 : 2;
        nd = 8 / db;
        model(a, b, s, res, ec, eo);
        got_word = '0;
        for (int i = 0; i < n_send; i++) begin
            ad   = 2'((a >> (i * db)) & ((1 << db) - 1));
            bd   = 2'((b >> (i * db)) & ((1 << db) - 1));
            rd   = 2'((res >> (i * db)) & ((1 << db) - 1));
            last = (i == nd - 1);
            step(which, $sformatf("%s d%0d", name, i), 1'b1, ad, bd,
                 (i == 0) ? s : 1'($urandom), rd, last, last && ec, last && eo, got);
            got_word = got_word | 8'(int'(got) << (i * db));
            if (i == bub_at)
                for (int k = 0; k < bub_n; k++) bubble(which, name);
            if (rand_bub && !last && $urandom_range(0, 3) == 0)
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) bubble(which, name);
        end
        if (n_send == nd)
            $display("%s dut%0d %02h %s %02h -> out %02h (model %02h cout %0b ovf %0b)",
                     name, which, a, s ? "-" : "+", b, got_word, res, ec, eo);
        else
            $display("%s dut%0d %02h %s %02h aborted after %0d digits",
                     name, which, a, s ? "-" : "+", b, n_send);
    endtask

    // Reset asserted between edges: outputs must clear without a clock edge.
    task automatic reset_mid(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, " rst out_val1"}, 32'(o_val1), 32'd0);
        chk({tag, " rst out1"},     32'(o1),     32'd0);
        chk({tag, " rst done1"},    32'(done1),  32'd0);
        chk({tag, " rst cout1"},    32'(cout1),  32'd0);
        chk({tag, " rst ovf1"},     32'(ovf1),   32'd0);
        chk({tag, " rst out_val2"}, 32'(o_val2), 32'd0);
        chk({tag, " rst out2"},     32'(o2),     32'd0);
        chk({tag, " rst done2"},    32'(done2),  32'd0);
        chk({tag, " rst cout2"},    32'(cout2),  32'd0);
        chk({tag, " rst ovf2"},     32'(ovf2),   32'd0);
        #2;
        reset = 1'b0;
        $display("%s reset pulse applied", tag);
    endtask

    initial begin
        int         which, k;
        logic [7:0] ra, rb;
        bit         rs;

        reset = 1'b1;
        v1 = 0; a1 = 0; b1 = 0; s1 = 0;
        v2 = 0; a2 = 0; b2 = 0; s2 = 0;
        #12;
        chk("init out_val1", 32'(o_val1), 32'd0);
        chk("init done1",    32'(done1),  32'd0);
        chk("init out_val2", 32'(o_val2), 32'd0);
        chk("init out2",     32'(o2),     32'd0);
        reset = 1'b0;

        // Directed words, back to back.
        run_word(1, "t1", 8'h0F, 8'h01, 1'b0, -1, 0, 1'b0, 8);
        run_word(1, "t2a", 8'h7F, 8'h01, 1'b0, -1, 0, 1'b0, 8);
        run_word(1, "t2b", 8'hFF, 8'h01, 1'b0, -1, 0, 1'b0, 8);
        run_word(1, "t3a", 8'h05, 8'h07, 1'b1, -1, 0, 1'b0, 8);
        run_word(1, "t3b", 8'h80, 8'h01, 1'b1, -1, 0, 1'b0, 8);
        run_word(1, "t4", 8'h0F, 8'h01, 1'b0, 2, 3, 1'b0, 8);
        run_word(1, "t5p", 8'hFF, 8'hFF, 1'b0, -1, 0, 1'b0, 3);
        reset_mid("t5");
        run_word(1, "t5", 8'h01, 8'h01, 1'b0, -1, 0, 1'b0, 8);
        run_word(2, "t6", 8'hB4, 8'h4C, 1'b0, -1, 0, 1'b0, 4);

        // Randomized words with bubbles and occasional mid-word resets.
        for (int w = 0; w < 100; w++) begin
            which = (w % 3 == 0) ? 1 : 2;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(1, (which == 1) ? 7 : 3);
                run_word(which, $sformatf("r%0d", w), ra, rb, rs, -1, 0, 1'b1, k);
                reset_mid($sformatf("r%0d", w));
            end else begin
                run_word(which, $sformatf("r%0d", w), ra, rb, rs, -1, 0, 1'b1,
                         (which == 1) ? 8 : 4);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
